pac_seq_ctrl: RTL and testbench
===============================

# pac_seq_ctrl

Sequencer for the scalar-unit program address counter (PACUnit). It steps PACUnit through program load, run, conditional-branch wait, drain and completion. It generates PACUnit's store request, fetch request and force-stall. It also tracks outstanding instruction fetches, detects end of program, and guards branch-condition waits with a watchdog.

## Interface
- ADDR_W, 32, program address width (matches address_t)
- DEPTH, 4, maximum outstanding fetches (instruction buffer slots), ≥1
- TIMEOUT, 255, WAIT_COND cycles before error, ≥1
- CNT_W, 16, width of fetch counter

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- I_Load  in  1  program-load command
- I_Load_Done  in  1  program load finished
- I_Start  in  1  start execution (honoured only in IDLE)
- I_Abort  in  1  abort current activity
- I_Clear  in  1  clear ERROR
- I_End_Addr  in  ADDR_W  last program address
- I_PAC_Address  in  ADDR_W  PACUnit O_Address
- I_PAC_StallReq  in  1  PACUnit O_StallReq
- I_Stall_Ext  in  1  pipeline hazard stall
- I_IF_Ack  in  1  instruction buffer consumed one fetch
- I_Is_Branch  in  1  decoded instruction is a conditional branch (1-cycle pulse)
- I_Cond_Valid  in  1  branch condition available
- I_Halt  in  1  decoded halt instruction
- O_Req_St  out  1  to PACUnit I_Req_St
- O_Req  out  1  to PACUnit I_Req
- O_Stall  out  1  to PACUnit I_Stall
- O_Busy  out  1  state not IDLE/DONE
- O_Done  out  1  completion pulse
- O_Err  out  1  watchdog error
- O_Fetch_Cnt  out  CNT_W  fetch requests issued in this run

## Operation
- States: IDLE, LOAD, RUN, WAIT_COND, DRAIN, DONE, ERROR. State is registered. Outputs are combinational from state, registers and the current-cycle stall inputs.
- IDLE: all outputs 0.
  - I_Load → LOAD. I_Load has priority over I_Start.
  - I_Start → RUN. O_Fetch_Cnt and the inflight counter clear.
- LOAD: O_Req_St=1 every cycle.
  - I_Load_Done → IDLE.
  - I_Abort → IDLE.
- RUN: O_Req = (inflight<DEPTH) & ~I_Stall_Ext & ~I_PAC_StallReq.
  - Each O_Req cycle increments O_Fetch_Cnt. The counter saturates at all-ones.
  - Priority order:
    1. I_Abort → DRAIN
    2. I_Halt → DRAIN
    3. O_Req & I_PAC_Address==I_End_Addr → DRAIN (that final fetch is issued)
    4. I_Is_Branch & ~I_Cond_Valid → WAIT_COND (watchdog cleared)
  - I_Is_Branch with I_Cond_Valid in the same cycle stays in RUN.
- WAIT_COND: O_Req=0, O_Stall=1. Watchdog increments each cycle.
  - I_Abort → DRAIN.
  - I_Cond_Valid → RUN.
  - Watchdog==TIMEOUT-1 with no I_Cond_Valid → ERROR. I_Cond_Valid on that cycle wins.
- DRAIN: O_Req=0, O_Stall=0. When inflight==0 (registered value) → DONE.
- DONE: O_Done=1 for exactly one cycle, then → IDLE. O_Fetch_Cnt holds until next I_Start.
- ERROR: O_Err=1, O_Stall=1. I_Clear → IDLE. I_Abort is ignored.
- Inflight counter (width clog2(DEPTH+1)):
  - +1 on O_Req, −1 on I_IF_Ack.
  - Both in the same cycle: unchanged.
  - I_IF_Ack at 0 without O_Req: ignored, no underflow.
  - The counter keeps updating from I_IF_Ack in every state.
- I_Start outside IDLE and I_Load outside IDLE are ignored.

## Timing
- Reset: state IDLE, inflight 0, watchdog 0, O_Fetch_Cnt 0. All outputs 0.
- I_Start at cycle n → RUN at n+1. First O_Req at n+1 if not stalled.
- O_Req falls in the same cycle that I_Stall_Ext or I_PAC_StallReq rises. There is no registered delay.
- Branch entry: the pulse at cycle n gives O_Stall=1 from n+1. I_Cond_Valid at m gives RUN at m+1 and O_Req at m+1 at the earliest.
- Timeout: entering WAIT_COND at n with no I_Cond_Valid gives ERROR (O_Err=1) at cycle n+TIMEOUT.
- Halt at n: DRAIN at n+1. With inflight 0, DONE at n+2 and O_Done pulse at n+2, IDLE at n+3.
- Reset mid-operation returns to IDLE on the next edge. All counters clear.

## Test plan
- Load: I_Load 1 cycle, I_Load_Done 5 cycles later → O_Req_St=1 for exactly 5 cycles, then IDLE, O_Busy=0.
- Run to end: DEPTH=4, I_End_Addr=9, PAC increments per O_Req, I_IF_Ack every cycle after 2-cycle lag → 10 requests, O_Fetch_Cnt=10, single O_Done pulse after final ack, inflight never >4.
- Backpressure: no I_IF_Ack → O_Req drops after 4 requests. One ack → exactly one more O_Req.
- Branch: I_Is_Branch without I_Cond_Valid → O_Stall=1, O_Req=0. I_Cond_Valid after 7 cycles → RUN next cycle, O_Err=0. Same-cycle branch+cond_valid → no stall.
- Watchdog: TIMEOUT=8, no cond → O_Err=1 exactly 8 cycles after entering WAIT_COND. I_Abort ignored. I_Clear → IDLE.
- Abort/reset: I_Abort in RUN with 3 inflight → DRAIN, O_Done after 3rd ack. Reset in WAIT_COND → all outputs 0 next cycle.

Source files
------------

// File: rtl/pac_seq_ctrl.sv
// pac_seq_ctrl: PACUnit sequencer for load/run/branch-wait/drain with fetch tracking and a branch-wait watchdog
module pac_seq_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_Load,
    input  logic              I_Load_Done,
    input  logic              I_Start,
    input  logic              I_Abort,
    input  logic              I_Clear,
    input  logic [ADDR_W-1:0] I_End_Addr,
    input  logic [ADDR_W-1:0] I_PAC_Address,
    input  logic              I_PAC_StallReq,
    input  logic              I_Stall_Ext,
    input  logic              I_IF_Ack,
    input  logic              I_Is_Branch,
    input  logic              I_Cond_Valid,
    input  logic              I_Halt,
    output logic              O_Req_St,
    output logic              O_Req,
    output logic              O_Stall,
    output logic              O_Busy,
    output logic              O_Done,
    output logic              O_Err,
    output logic [CNT_W-1:0]  O_Fetch_Cnt
);
    localparam int IF_W = $clog2(DEPTH + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [IF_W-1:0] DEPTH_C = IF_W'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT_COND, DRAIN, DONE, ERROR} state_t;

    state_t          state_q, state_d;
    logic [IF_W-1:0] inflight_q, inflight_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req;

    always_comb begin
        req        = state_q == RUN && inflight_q < DEPTH_C && !I_Stall_Ext && !I_PAC_StallReq;
        state_d    = state_q;
        wd_d       = wd_q;
        cnt_d      = (req && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        inflight_d = (req && !I_IF_Ack) ? inflight_q + 1'b1 :
                     (!req && I_IF_Ack && inflight_q != '0) ? inflight_q - 1'b1 : inflight_q;
        case (state_q)
            IDLE: begin
                if (I_Load) begin
                    state_d = LOAD;
                end else if (I_Start) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    inflight_d = '0;
                end
            end
            LOAD: state_d = (I_Load_Done || I_Abort) ? IDLE : LOAD;
            RUN: begin
                if (I_Abort || I_Halt || (req && I_PAC_Address == I_End_Addr)) begin
                    state_d = DRAIN;
                end else if (I_Is_Branch && !I_Cond_Valid) begin
                    state_d = WAIT_COND;
                    wd_d    = '0;
                end
            end
            WAIT_COND: begin
                wd_d    = wd_q + 1'b1;
                state_d = I_Abort ? DRAIN : I_Cond_Valid ? RUN : (wd_q == WD_LAST) ? ERROR : WAIT_COND;
            end
            DRAIN:   state_d = (inflight_q == '0) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            ERROR:   state_d = I_Clear ? IDLE : ERROR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            wd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            wd_q       <= wd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign O_Req_St    = state_q == LOAD;
    assign O_Req       = req;
    assign O_Stall     = state_q == WAIT_COND || state_q == ERROR;
    assign O_Busy      = !(state_q == IDLE || state_q == DONE);
    assign O_Done      = state_q == DONE;
    assign O_Err       = state_q == ERROR;
    assign O_Fetch_Cnt = cnt_q;
endmodule

// File: tb/tb_pac_seq_ctrl.sv
// tb_pac_seq_ctrl: directed bench for pac_seq_ctrl with DEPTH=4, TIMEOUT=8
module tb_pac_seq_ctrl;
    logic        clock = 0;
    logic        reset = 1;
    logic        I_Load = 0, I_Load_Done = 0, I_Start = 0, I_Abort = 0, I_Clear = 0;
    logic [31:0] I_End_Addr = 1000, I_PAC_Address = 0;
    logic        I_PAC_StallReq = 0, I_Stall_Ext = 0, I_IF_Ack = 0;
    logic        I_Is_Branch = 0, I_Cond_Valid = 0, I_Halt = 0;
    logic        O_Req_St, O_Req, O_Stall, O_Busy, O_Done, O_Err;
    logic [15:0] O_Fetch_Cnt;
    int          n_tests = 0;
    int          n_fail = 0;

    pac_seq_ctrl #(.ADDR_W(32), .DEPTH(4), .TIMEOUT(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .I_Load(I_Load), .I_Load_Done(I_Load_Done),
        .I_Start(I_Start), .I_Abort(I_Abort), .I_Clear(I_Clear), .I_End_Addr(I_End_Addr),
        .I_PAC_Address(I_PAC_Address), .I_PAC_StallReq(I_PAC_StallReq),
        .I_Stall_Ext(I_Stall_Ext), .I_IF_Ack(I_IF_Ack), .I_Is_Branch(I_Is_Branch),
        .I_Cond_Valid(I_Cond_Valid), .I_Halt(I_Halt), .O_Req_St(O_Req_St), .O_Req(O_Req),
        .O_Stall(O_Stall), .O_Busy(O_Busy), .O_Done(O_Done), .O_Err(O_Err),
        .O_Fetch_Cnt(O_Fetch_Cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int          reqs, dones, first, st;
        logic [31:0] pac;
        logic [1:0]  hist;
        logic        nreq;
        repeat (2) step();
        reset = 0;
        #2;
        check("rst_busy", O_Busy, 0);
        check("rst_req", O_Req, 0);
        check("rst_req_st", O_Req_St, 0);
        check("rst_stall", O_Stall, 0);
        check("rst_done", O_Done, 0);
        check("rst_err", O_Err, 0);
        check("rst_cnt", O_Fetch_Cnt, 0);
        // Load wins over Start in the same cycle
        I_Load = 1; I_Start = 1;
        step();
        I_Load = 0; I_Start = 0;
        st = 0;
        for (int i = 0; i < 8; i++) begin
            I_Load_Done = (i == 4);
            #2;
            if (i == 0) check("load_busy", O_Busy, 1);
            st += int'(O_Req_St);
            step();
        end
        I_Load_Done = 0;
        #2;
        check("load_req_st_cycles", st, 5);
        check("load_then_idle", O_Busy, 0);
        check("load_start_ignored", O_Req, 0);
        // Run to end address 9 with acks two cycles after each request
        I_End_Addr = 9; I_Start = 1;
        step();
        I_Start = 0;
        pac = 0; hist = 0; reqs = 0; dones = 0; first = -1;
        for (int i = 0; i < 30; i++) begin
            I_PAC_Address = pac;
            I_IF_Ack = hist[1];
            #2;
            nreq = O_Req;
            reqs += int'(O_Req);
            if (O_Done) begin
                dones++;
                if (first < 0) first = i;
            end
            step();
            pac = pac + 32'(nreq);
            hist = {hist[0], nreq};
        end
        I_IF_Ack = 0; I_PAC_Address = 0; I_End_Addr = 1000;
        #2;
        check("run_reqs", reqs, 10);
        check("run_done_pulses", dones, 1);
        check("run_done_cycle", first, 13);
        check("run_fetch_cnt", O_Fetch_Cnt, 10);
        check("run_idle_busy", O_Busy, 0);
        // Backpressure and stall inputs
        I_Start = 1;
        step();
        I_Start = 0; I_Stall_Ext = 1;
        #2;
        check("stall_ext_blocks", O_Req, 0);
        check("fetch_cnt_cleared", O_Fetch_Cnt, 0);
        step();
        I_Stall_Ext = 0; I_PAC_StallReq = 1;
        #2;
        check("pac_stall_blocks", O_Req, 0);
        step();
        I_PAC_StallReq = 0;
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            reqs += int'(O_Req);
            step();
        end
        check("bp_reqs", reqs, 4);
        I_IF_Ack = 1;
        #2;
        check("bp_ack_cycle_req", O_Req, 0);
        step();
        I_IF_Ack = 0;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            reqs += int'(O_Req);
            step();
        end
        check("bp_one_more", reqs, 1);
        check("bp_fetch_cnt", O_Fetch_Cnt, 5);
        reset = 1;
        step();
        reset = 0;
        // Halt with nothing in flight
        I_Start = 1;
        step();
        I_Start = 0; I_Halt = 1; I_Stall_Ext = 1;
        step();
        I_Halt = 0; I_Stall_Ext = 0;
        #2;
        check("halt_drain_busy", O_Busy, 1);
        check("halt_no_early_done", O_Done, 0);
        step();
        #2;
        check("halt_done", O_Done, 1);
        check("halt_done_busy", O_Busy, 0);
        step();
        #2;
        check("halt_done_pulse", O_Done, 0);
        // Abort with 3 fetches in flight
        I_Start = 1;
        step();
        I_Start = 0;
        repeat (3) step();
        I_Abort = 1; I_Stall_Ext = 1;
        #2;
        check("abort_cycle_req", O_Req, 0);
        check("abort_fetch_cnt", O_Fetch_Cnt, 3);
        step();
        I_Abort = 0; I_Stall_Ext = 0;
        dones = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            I_IF_Ack = (i == 0 || i == 2 || i == 4);
            #2;
            if (O_Done) begin
                dones++;
                if (first < 0) first = i;
            end
            step();
        end
        I_IF_Ack = 0;
        check("abort_done_cycle", first, 6);
        check("abort_done_pulses", dones, 1);
        // Branch wait resolved on the last watchdog cycle
        I_IF_Ack = 1; I_Start = 1;
        step();
        I_Start = 0; I_Is_Branch = 1;
        #2;
        check("br_pulse_no_stall", O_Stall, 0);
        step();
        I_Is_Branch = 0;
        st = 0;
        for (int i = 0; i < 8; i++) begin
            I_Cond_Valid = (i == 7);
            #2;
            st += int'(O_Stall && !O_Req);
            step();
        end
        I_Cond_Valid = 0;
        #2;
        check("br_stall_cycles", st, 8);
        check("br_resume_req", O_Req, 1);
        check("br_resume_stall", O_Stall, 0);
        check("br_resume_err", O_Err, 0);
        I_Is_Branch = 1; I_Cond_Valid = 1;
        step();
        I_Is_Branch = 0; I_Cond_Valid = 0;
        #2;
        check("br_same_cycle_stall", O_Stall, 0);
        check("br_same_cycle_req", O_Req, 1);
        // Watchdog expiry, abort ignored in ERROR, clear
        I_Is_Branch = 1;
        step();
        I_Is_Branch = 0;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (O_Err && first < 0) first = i;
            step();
        end
        check("wd_err_cycle", first, 8);
        I_Abort = 1;
        step();
        I_Abort = 0;
        #2;
        check("err_abort_ignored", O_Err, 1);
        check("err_stall", O_Stall, 1);
        I_Clear = 1;
        step();
        I_Clear = 0;
        #2;
        check("clear_err", O_Err, 0);
        check("clear_busy", O_Busy, 0);
        // Reset while waiting on a branch condition
        I_Start = 1;
        step();
        I_Start = 0; I_Is_Branch = 1;
        step();
        I_Is_Branch = 0;
        #2;
        check("wait_stall", O_Stall, 1);
        reset = 1;
        step();
        reset = 0;
        #2;
        check("rst_wait_stall", O_Stall, 0);
        check("rst_wait_busy", O_Busy, 0);
        check("rst_wait_cnt", O_Fetch_Cnt, 0);
        check("rst_wait_req", O_Req, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
